dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port. Accepts one request at a time
//  over a valid/ready handshake, inserts WAIT_STATES cycles of access latency, then
//  returns read data or write completion over a valid/ready response channel.
//  Sits between the processor's data-memory port and the on-chip word RAM. Lets the
//  pipelined core evolve toward realistic, non-zero-latency memory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words stored; word index = (req_addr-BASE_ADDR)>>2
//  BASE_ADDR    0    byte address of word 0; must be 4-byte aligned
//  WAIT_STATES  2    extra cycles between accept and response; legal range 0..15
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; request transfers when req_valid&req_ready
//  req_write   in   1   1=store, 0=load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data
//  req_be      in   4   byte-lane mask; bit i = bits[8i+7:8i]; ignored unless DMEM_BYTE_WRITE_EN
//  resp_valid  out  1   response present; held until resp_ready
//  resp_ready  in   1   requester accepts response
//  resp_rdata  out  32  load data; 0 for stores and errors
//  resp_err    out  1   access failed (out of range or misaligned); no store performed
// BEHAVIOUR
//  - FSM states IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational from state.
//  - Reset: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0;
//    req_ready=1 from first cycle after reset. RAM contents not reset.
//  - IDLE: on accept, latch write/addr/wdata/be. Go to WAIT with counter=WAIT_STATES-1,
//    or directly to RESP when WAIT_STATES==0.
//  - WAIT: counter decrements each cycle; at 0 go to RESP.
//  - On entry to RESP (same edge): error check; store commits to RAM, or load samples
//    RAM into resp_rdata; resp_err set. Response latency = WAIT_STATES+1 cycles after accept.
//  - RESP: resp_valid=1, outputs stable until resp_valid&resp_ready, then IDLE
//    (resp_valid=0). No new request accepted in the handoff cycle; one outstanding max.
//  - Out-of-range (addr<BASE_ADDR or index>=DEPTH_WORDS): resp_err=1, rdata=0, no write.
//  - Address arithmetic in 32 bits unsigned; no wrap: BASE_ADDR+4*DEPTH_WORDS overflow
//    is a configuration error (elaboration-time assertion).
//  - reset mid-WAIT aborts the request; its store is never committed. reset in RESP
//    drops the response; the committed store stays in RAM.
//  - req inputs changing while not ready are ignored.
// CONFIGURATION
//  Macro DMEM_BYTE_WRITE_EN:
//  - defined: stores write only lanes with req_be[i]=1; req_addr[1:0] ignored for
//    alignment; store with req_be==4'b0000 -> resp_err=1. Loads ignore addr[1:0],
//    return full word.
//  - undefined: req_be ignored; stores write all four lanes; any access with
//    req_addr[1:0]!=0 -> resp_err=1, no write.
// STRUCTURE
//  - Package dmem_pkg: state enum (IDLE/WAIT/RESP), WORD_W=32, BE_W=4, ERR_NONE/ERR_*
//    localparams, index/range-check function.
//  - Sub-module dmem_ram_array: DEPTH_WORDS x 32 synchronous-write RAM with lane write
//    enables and combinational read; responder FSM owns all handshake logic.
// TESTING
//  - Reset, then store addr=0x10 data=0xDEADBEEF, WAIT_STATES=2 -> resp_valid 3 cycles
//    after accept, resp_err=0; load 0x10 -> rdata=0xDEADBEEF.
//  - Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout;
//    release -> IDLE next cycle, req_ready=1.
//  - Load addr=4*DEPTH_WORDS -> resp_err=1, rdata=0; store there -> RAM unchanged.
//  - Macro off: store addr=0x12 -> resp_err=1. Macro on: word 0x20=0x11223344,
//    store be=4'b0100 wdata=0xAABBCCDD -> load 0x20 = 0x11BB3344.
//  - Assert reset during WAIT of store to 0x30 (old 0x0) -> after reset load 0x30 = 0x0.
//  - WAIT_STATES=0 -> back-to-back load/store, each response 1 cycle after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int   WORD_W     = 32;
   localparam int   BE_W       = 4;
   localparam logic ERR_NONE   = 1'b0;
   localparam logic ERR_ACCESS = 1'b1;

   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

   // Unsigned compare; addresses below the base never wrap into range.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
      return (addr >= base) && (word_index(addr, base) < depth);
   endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Word RAM with per-lane synchronous write enables and combinational read.
module dmem_ram_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with fixed access latency in front of dmem_ram_array.
// Build option DMEM_BYTE_WRITE_EN enables byte-lane stores and relaxes alignment.
//
//  state | meaning
//  IDLE  | ready for a request
//  WAIT  | access latency countdown (cnt down to 0)
//  RESP  | response held until resp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [33:0] END_ADDR = 34'(BASE_ADDR) + 34'(DEPTH_WORDS) * 34'd4;
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   if (END_ADDR > 34'h1_0000_0000) begin : g_bad_range
      $error("dmem_responder: BASE_ADDR + 4*DEPTH_WORDS overflows the address space");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("dmem_responder: BASE_ADDR must be word aligned");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_STATES must be 0..15");
   end
   if (DEPTH_WORDS < 1) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be at least 1");
   end

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              accept, enter_resp;
   logic              lat_write;
   logic [31:0]       lat_addr;
   logic [WORD_W-1:0] lat_wdata;
   logic              acc_write;
   logic [31:0]       acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic [BE_W-1:0]   lane_be;
   logic              acc_err;
   logic [31:0]       acc_index;
   logic [WORD_W-1:0] ram_rdata;
   logic              ram_we;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
   end

   assign accept     = req_valid && req_ready;
   assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd0));

   // With zero wait states the access happens on the accept edge, so use live inputs.
   assign acc_write = (state == IDLE) ? req_write : lat_write;
   assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
   assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
   assign acc_index = word_index(acc_addr, BASE_ADDR);

`ifdef DMEM_BYTE_WRITE_EN
   logic [BE_W-1:0] lat_be, acc_be;
   assign acc_be  = (state == IDLE) ? req_be : lat_be;
   assign lane_be = acc_be;
   assign acc_err = !addr_in_range(acc_addr, BASE_ADDR, 32'(DEPTH_WORDS))
                    || (acc_write && (acc_be == '0));
`else
   logic unused_be;
   assign unused_be = ^req_be;
   assign lane_be   = '1;
   assign acc_err   = !addr_in_range(acc_addr, BASE_ADDR, 32'(DEPTH_WORDS))
                      || (acc_addr[1:0] != 2'b00);
`endif

   logic unused_idx;
   assign unused_idx = ^acc_index[31:IDX_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= ERR_NONE;
`ifdef DMEM_BYTE_WRITE_EN
         lat_be     <= '0;
`endif
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
            lat_be    <= req_be;
`endif
            cnt       <= CNT_INIT;
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err   <= acc_err ? ERR_ACCESS : ERR_NONE;
            resp_rdata <= (acc_write || acc_err) ? '0 : ram_rdata;
         end
      end
   end

   assign ram_we = enter_resp && acc_write && !acc_err;

   dmem_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (lane_be),
      .idx   (acc_index[IDX_W-1:0]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: dut 0 has WAIT_STATES=2, dut 1 has WAIT_STATES=0.
module tb_dmem_responder;

   typedef struct {
      int          d;
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [3:0]  req_be     [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t cur [2];
   bit   in_resp [2];
   bit   handoff [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   function automatic int lat(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            in_resp[d] = 1'b0;
            handoff[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (handoff[d]) begin
               chk($sformatf("handoff_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
               chk($sformatf("handoff_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
               handoff[d] = 1'b0;
            end
            if (resp_valid[d]) begin
               if (!in_resp[d]) begin
                  if (sb.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_resp dut=%0d actual rdata=%h err=%b required none",
                              d, resp_rdata[d], resp_err[d]);
                     cur[d] = '{d, resp_rdata[d], resp_err[d], cyc - lat(d)};
                  end else begin
                     cur[d] = sb.pop_front();
                     chk($sformatf("resp_dut%0d", d), 32'(d), 32'(cur[d].d));
                     chk($sformatf("rdata%0d", d), resp_rdata[d], cur[d].rdata);
                     chk($sformatf("err%0d", d), 32'(resp_err[d]), 32'(cur[d].err));
                     chk($sformatf("latency%0d", d), 32'(cyc - cur[d].acc), 32'(lat(d)));
                  end
                  in_resp[d] = 1'b1;
               end else begin
                  chk($sformatf("stable_rdata%0d", d), resp_rdata[d], cur[d].rdata);
                  chk($sformatf("stable_err%0d", d), 32'(resp_err[d]), 32'(cur[d].err));
               end
               chk($sformatf("busy_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
               if (resp_ready[d]) begin
                  in_resp[d] = 1'b0;
                  handoff[d] = 1'b1;
               end
            end else if (in_resp[d]) begin
               total++;
               bad++;
               $display("FAIL resp_dropped dut=%0d actual resp_valid=0 required 1", d);
               in_resp[d] = 1'b0;
            end
         end
      end
   end

   task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er, input bit ee, input bit push);
      int n = 0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_write[d] = w;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_be[d]    = be;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         total++;
         bad++;
         $display("FAIL accept_timeout dut=%0d actual req_ready=0 required 1", d);
         req_valid[d] = 1'b0;
         return;
      end
      if (push) sb.push_back('{d, er, ee, cyc});
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'hFFFF_FFF0;
      req_wdata[d] = 32'h5A5A_5A5A;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || in_resp[0] || in_resp[1]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_state(input int d);
      chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(resp_err[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_write[d]  = 1'b0;
         req_addr[d]   = 32'h0;
         req_wdata[d]  = 32'h0;
         req_be[d]     = 4'hF;
         resp_ready[d] = 1'b1;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_reset_state(0);
      chk_reset_state(1);

      // basic store/load, latency 3
      issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
      issue(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
      // boundary words and out-of-range (index 256 must not alias word 0)
      issue(0, 1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0, 1);
      issue(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1);
      issue(0, 0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 1);
      issue(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1);
      issue(0, 0, 32'h0, 32'h0, 4'hF, 32'h01234567, 1'b0, 1);
      issue(0, 0, 32'h3FC, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1);
      issue(0, 0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0, 1'b1, 1);
`ifdef DMEM_BYTE_WRITE_EN
      issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1);
      issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0100, 32'h0, 1'b0, 1);
      issue(0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB3344, 1'b0, 1);
      issue(0, 1, 32'h21, 32'h99999999, 4'b0000, 32'h0, 1'b1, 1);
      issue(0, 1, 32'h23, 32'h000000EE, 4'b0001, 32'h0, 1'b0, 1);
      issue(0, 0, 32'h22, 32'h0, 4'hF, 32'h11BB33EE, 1'b0, 1);
`else
      issue(0, 1, 32'h12, 32'h77777777, 4'hF, 32'h0, 1'b1, 1);
      issue(0, 0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, 1);
      issue(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
`endif
      drain();

      // response back-pressure
      resp_ready[0] = 1'b0;
      issue(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);
      n = 0;
      while (!resp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid[0]) begin
         total++;
         bad++;
         $display("FAIL stall_resp_timeout actual resp_valid=0 required 1");
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      resp_ready[0] = 1'b1;
      drain();

      // reset during WAIT aborts the store
      issue(0, 1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1);
      drain();
      issue(0, 1, 32'h30, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_state(0);
      issue(0, 0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1);
      drain();

      // zero wait states
      issue(1, 1, 32'h40, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1);
      issue(1, 0, 32'h40, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1);
      issue(1, 1, 32'h44, 32'h13572468, 4'hF, 32'h0, 1'b0, 1);
      issue(1, 0, 32'h44, 32'h0, 4'hF, 32'h13572468, 1'b0, 1);
      issue(1, 1, 32'h400, 32'h1, 4'hF, 32'h0, 1'b1, 1);
      issue(1, 0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 1);
      issue(1, 0, 32'h40, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
